// File: rtl/input_pkg.sv
// Shared types and defaults for the switch/button input controller.
// Holds the FSM state encoding, read-mode encodings and default widths.
package input_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        CAPTURED   = 2'd2
    } input_state_t;

    localparam logic READ_MODE_WAIT      = 1'b0;
    localparam logic READ_MODE_IMMEDIATE = 1'b1;

    localparam int DEFAULT_SWITCH_WIDTH = 18;
    localparam int DEFAULT_DATA_WIDTH   = 32;

endpackage

// File: rtl/input_controller_button_debouncer.sv
// Confirm-button front end: 2-flop synchroniser, stability filter and a
// registered one-cycle pulse on every accepted 0->1 transition.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic button_level,
    output logic press_pulse
);

    localparam int COUNT_WIDTH = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [1:0] sync_reg;
    logic       button_synced;
    logic       stable_reg;
    logic       pulse_reg;

    assign button_synced = sync_reg[1];
    assign button_level  = stable_reg;
    assign press_pulse   = pulse_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], button};
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    stable_reg <= 1'b0;
                    pulse_reg  <= 1'b0;
                end else begin
                    stable_reg <= button_synced;
                    pulse_reg  <= button_synced & ~stable_reg;
                end
            end
        end else begin : g_filter
            localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

            logic [COUNT_WIDTH-1:0] count_reg;

            // The level flips on the edge where the count would reach
            // DEBOUNCE_CYCLES; the pulse is registered on that same edge.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg  <= '0;
                    stable_reg <= 1'b0;
                    pulse_reg  <= 1'b0;
                end else begin
                    pulse_reg <= 1'b0;
                    if (button_synced == stable_reg) begin
                        count_reg <= '0;
                    end else if (count_reg == COUNT_LAST) begin
                        count_reg  <= '0;
                        stable_reg <= button_synced;
                        pulse_reg  <= button_synced;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/input_controller.sv
// IN-instruction input unit: stalls the CPU until a debounced button press
// (or samples at once in immediate mode) and latches the extended switches.
module input_controller
    import input_pkg::*;
#(
    parameter int SWITCH_WIDTH    = DEFAULT_SWITCH_WIDTH,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SIGN_EXTEND     = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    read_request,
    input  logic                    read_mode,
    input  logic                    button,
    input  logic [SWITCH_WIDTH-1:0] switches,
    output logic                    halt_from_input,
    output logic                    data_valid,
    output logic [DATA_WIDTH-1:0]   output_value,
    output logic                    button_level
);

    input_state_t state_reg;
    input_state_t state_next;
    logic         capture;
    logic         press_pulse;
    logic         data_valid_reg;

    logic [SWITCH_WIDTH-1:0] switch_meta_reg;
    logic [SWITCH_WIDTH-1:0] switch_sync_reg;
    logic [DATA_WIDTH-1:0]   extended_value;
    logic [DATA_WIDTH-1:0]   value_reg;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock       (clock),
        .reset_n     (reset_n),
        .button      (button),
        .button_level(button_level),
        .press_pulse (press_pulse)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            switch_meta_reg <= '0;
            switch_sync_reg <= '0;
        end else begin
            switch_meta_reg <= switches;
            switch_sync_reg <= switch_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_extend
            if (gi < SWITCH_WIDTH) begin : g_bit
                assign extended_value[gi] = switch_sync_reg[gi];
            end else begin : g_fill
                assign extended_value[gi] = (SIGN_EXTEND != 0) ? switch_sync_reg[SWITCH_WIDTH-1] : 1'b0;
            end
        end
    endgenerate

    // A press arriving on the IDLE->WAIT_PRESS edge is deliberately dropped,
    // and an abort in WAIT_PRESS beats a simultaneous press.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (read_request) begin
                    if (read_mode == READ_MODE_IMMEDIATE) begin
                        capture    = 1'b1;
                        state_next = CAPTURED;
                    end else begin
                        state_next = WAIT_PRESS;
                    end
                end
            end
            WAIT_PRESS: begin
                if (!read_request) begin
                    state_next = IDLE;
                end else if (press_pulse) begin
                    capture    = 1'b1;
                    state_next = CAPTURED;
                end
            end
            CAPTURED: begin
                if (!read_request) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            data_valid_reg <= 1'b0;
            value_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            data_valid_reg <= capture;
            if (capture) begin
                value_reg <= extended_value;
            end
        end
    end

    assign halt_from_input = reset_n && read_request && (state_reg != CAPTURED) &&
                             (read_mode == READ_MODE_WAIT);
    assign data_valid      = data_valid_reg;
    assign output_value    = value_reg;

endmodule

// File: tb/tb_input_controller.sv
// Self-checking bench for input_controller with a 4-cycle debounce filter;
// a zero-extending and a sign-extending instance share the same stimulus.
module tb_input_controller;

    logic        clock;
    logic        reset_n;
    logic        read_request;
    logic        read_mode;
    logic        button;
    logic [17:0] switches;

    logic        halt_zero, halt_sign;
    logic        dv_zero, dv_sign;
    logic [31:0] out_zero, out_sign;
    logic        level_zero, level_sign;

    int n_compared   = 0;
    int n_mismatched = 0;

    input_controller #(
        .SWITCH_WIDTH(18), .DATA_WIDTH(32), .DEBOUNCE_CYCLES(4), .SIGN_EXTEND(0)
    ) dut_zero (
        .clock(clock), .reset_n(reset_n), .read_request(read_request),
        .read_mode(read_mode), .button(button), .switches(switches),
        .halt_from_input(halt_zero), .data_valid(dv_zero),
        .output_value(out_zero), .button_level(level_zero)
    );

    input_controller #(
        .SWITCH_WIDTH(18), .DATA_WIDTH(32), .DEBOUNCE_CYCLES(4), .SIGN_EXTEND(1)
    ) dut_sign (
        .clock(clock), .reset_n(reset_n), .read_request(read_request),
        .read_mode(read_mode), .button(button), .switches(switches),
        .halt_from_input(halt_sign), .data_valid(dv_sign),
        .output_value(out_sign), .button_level(level_sign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [17:0] sw;
        logic [31:0] exp_zero;
        logic [31:0] exp_sign;
    } imm_vec_t;

    imm_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance n edges, counting data_valid pulses from the zero-extend instance.
    task automatic run_cycles(input int n, output int pulses, output int first_edge);
        pulses     = 0;
        first_edge = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (dv_zero) begin
                pulses++;
                if (first_edge == 0) first_edge = i;
            end
        end
    endtask

    initial begin
        int pulses, first_edge, total;

        vecs[0] = '{18'h20001, 32'h00020001, 32'hFFFE0001};
        vecs[1] = '{18'h1FFFF, 32'h0001FFFF, 32'h0001FFFF};
        vecs[2] = '{18'h3FFFF, 32'h0003FFFF, 32'hFFFFFFFF};
        vecs[3] = '{18'h00000, 32'h00000000, 32'h00000000};
        vecs[4] = '{18'h2A5F5, 32'h0002A5F5, 32'hFFFEA5F5};

        reset_n      = 1'b0;
        read_request = 1'b1;
        read_mode    = 1'b0;
        button       = 1'b0;
        switches     = 18'h0;
        tick();
        tick();
        check("reset_halt", {31'b0, halt_zero}, 32'd0);
        check("reset_dv", {31'b0, dv_zero}, 32'd0);
        check("reset_out", out_zero, 32'd0);
        check("reset_level", {31'b0, level_zero}, 32'd0);
        $display("reset state checked");
        read_request = 1'b0;
        reset_n      = 1'b1;
        tick();

        // Immediate mode, table-driven
        for (int v = 0; v < 5; v++) begin
            read_mode    = 1'b1;
            read_request = 1'b0;
            switches     = vecs[v].sw;
            tick(); tick(); tick();
            read_request = 1'b1;
            #1;
            check("imm_halt_pre", {31'b0, halt_zero}, 32'd0);
            tick();
            check("imm_dv", {30'b0, dv_zero, dv_sign}, 32'd3);
            check("imm_out_zero", out_zero, vecs[v].exp_zero);
            check("imm_out_sign", out_sign, vecs[v].exp_sign);
            check("imm_halt", {31'b0, halt_zero}, 32'd0);
            tick();
            check("imm_dv_once", {31'b0, dv_zero}, 32'd0);
            read_request = 1'b0;
            tick();
            $display("vec %0d sw=%h zero=%h sign=%h", v, vecs[v].sw, out_zero, out_sign);
        end

        // Wait-mode capture with a clean rise
        read_mode = 1'b0;
        switches  = 18'h2A5F5;
        tick(); tick(); tick();
        read_request = 1'b1;
        #1;
        check("wait_halt_same_cycle", {31'b0, halt_zero}, 32'd1);
        tick(); tick();
        button = 1'b1;
        run_cycles(6, pulses, first_edge);
        check("wait_no_early_dv", pulses, 0);
        check("wait_halt_before", {31'b0, halt_zero}, 32'd1);
        tick();
        check("wait_dv_edge7", {31'b0, dv_zero}, 32'd1);
        check("wait_halt_falls", {31'b0, halt_zero}, 32'd0);
        check("wait_out", out_zero, 32'h0002A5F5);
        tick();
        check("wait_dv_pulse", {31'b0, dv_zero}, 32'd0);
        $display("wait-mode capture out=%h", out_zero);
        read_request = 1'b0;
        button       = 1'b0;
        run_cycles(10, pulses, first_edge);
        check("release_level", {31'b0, level_zero}, 32'd0);

        // Bounce rejection
        read_request = 1'b1;
        tick();
        total = 0;
        for (int t = 0; t < 10; t++) begin
            button = (t % 2 == 0);
            run_cycles(2, pulses, first_edge);
            total += pulses;
        end
        check("bounce_no_dv", total, 0);
        check("bounce_level", {31'b0, level_zero}, 32'd0);
        button = 1'b1;
        run_cycles(12, pulses, first_edge);
        check("bounce_one_dv", pulses, 1);
        check("bounce_dv_edge", first_edge, 7);
        $display("bounce: pulses=%0d first_edge=%0d", pulses, first_edge);
        read_request = 1'b0;
        button       = 1'b0;
        run_cycles(10, pulses, first_edge);

        // Held button must be released and pressed again
        switches = 18'h0ABCD;
        button   = 1'b1;
        run_cycles(10, pulses, first_edge);
        read_request = 1'b1;
        #1;
        check("held_halt", {31'b0, halt_zero}, 32'd1);
        run_cycles(15, pulses, first_edge);
        check("held_no_dv", pulses, 0);
        check("held_halt_stays", {31'b0, halt_zero}, 32'd1);
        button = 1'b0;
        run_cycles(10, pulses, first_edge);
        check("held_release_no_dv", pulses, 0);
        button = 1'b1;
        run_cycles(10, pulses, first_edge);
        check("held_repress_dv", pulses, 1);
        check("held_repress_edge", first_edge, 7);
        check("held_out", out_zero, 32'h0000ABCD);
        $display("held button: pulses=%0d out=%h", pulses, out_zero);
        read_request = 1'b0;
        button       = 1'b0;
        run_cycles(10, pulses, first_edge);

        // Abort coinciding with press_pulse
        switches     = 18'h12345;
        read_request = 1'b1;
        tick();
        button = 1'b1;
        run_cycles(6, pulses, first_edge);
        check("abort_pulse_present", {31'b0, dut_zero.press_pulse}, 32'd1);
        read_request = 1'b0;
        run_cycles(5, pulses, first_edge);
        check("abort_no_dv", pulses, 0);
        check("abort_out_kept", out_zero, 32'h0000ABCD);
        check("abort_halt", {31'b0, halt_zero}, 32'd0);
        $display("abort: out=%h", out_zero);
        button = 1'b0;
        run_cycles(10, pulses, first_edge);

        // Long request with three presses
        switches     = 18'h00777;
        tick(); tick();
        read_request = 1'b1;
        total = 0;
        for (int p = 0; p < 3; p++) begin
            button = 1'b1;
            run_cycles(8, pulses, first_edge);
            total += pulses;
            button = 1'b0;
            run_cycles(10, pulses, first_edge);
            total += pulses;
        end
        run_cycles(46, pulses, first_edge);
        total += pulses;
        check("long_one_capture", total, 1);
        check("long_out", out_zero, 32'h00000777);
        $display("long request: captures=%0d out=%h", total, out_zero);
        read_request = 1'b0;
        tick();

        // Asynchronous reset mid-run
        read_mode = 1'b1;
        switches  = 18'h3FFFF;
        tick(); tick(); tick();
        read_request = 1'b1;
        tick();
        check("pre_reset_dv", {31'b0, dv_zero}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_dv", {31'b0, dv_zero}, 32'd0);
        check("async_reset_out", out_zero, 32'd0);
        check("async_reset_out_sign", out_sign, 32'd0);
        read_request = 1'b0;
        read_mode    = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        read_request = 1'b1;
        #1;
        check("post_reset_halt", {31'b0, halt_zero}, 32'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_halt", {31'b0, halt_zero}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("halt_after_release", {31'b0, halt_zero}, 32'd1);
        $display("reset mid-run checked");
        read_request = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
